// File: rtl/dram_ctrl.sv
// Cache-side DRAM controller: single-beat and line-burst accesses over a
// one-outstanding req/ack memory port, with lane alignment and ack timeout.
module dram_ctrl #(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dram_addr,
  input  logic [63:0] dram_din,
  input  logic [2:0]  dram_rd_ctrl,
  input  logic [2:0]  dram_wr_ctrl,
  output logic [63:0] dram_dout,
  output logic [1:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_BEAT = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  state_t        r_state, w_state_next;
  logic [BW-1:0] r_beat, w_beat_next;
  logic [TW-1:0] r_tmo, w_tmo_next;
  logic [2:0]    r_off, w_off_next;
  logic [2:0]    r_size, w_size_next;
  logic          r_we, w_we_next;
  logic          r_burst, w_burst_next;
  logic [63:0]   r_dout, w_dout_next;
  logic          r_mem_req, w_mem_req_next;
  logic          r_mem_we, w_mem_we_next;
  logic [63:0]   r_mem_addr, w_mem_addr_next;
  logic [63:0]   r_mem_wdata, w_mem_wdata_next;
  logic [7:0]    r_mem_wstrb, w_mem_wstrb_next;

  logic          w_rd_ok, w_wr_ok, w_misalign;
  logic [2:0]    w_ctrl;
  logic [63:0]   w_shifted, w_rd_data;

  function automatic logic cmd_ok(input logic [2:0] c);
    return (c inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b110});
  endfunction

  function automatic logic [7:0] size_mask(input logic [2:0] c);
    case (c)
      3'b001:  return 8'h01;
      3'b010:  return 8'h03;
      3'b011:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  assign w_rd_ok    = cmd_ok(dram_rd_ctrl);
  assign w_wr_ok    = cmd_ok(dram_wr_ctrl);
  assign w_ctrl     = w_wr_ok ? dram_wr_ctrl : dram_rd_ctrl;
  assign w_misalign = ((w_ctrl == 3'b010) && dram_addr[0]) ||
                      ((w_ctrl == 3'b011) && (dram_addr[1:0] != 2'b00)) ||
                      ((w_ctrl == 3'b100) && (dram_addr[2:0] != 3'b000));

  // Singles are right-aligned to bit 0 and zero-extended to the access size.
  assign w_shifted = mem_rdata >> {r_off, 3'b000};
  always_comb begin
    w_rd_data = w_shifted;
    case (r_size)
      3'b001:  w_rd_data = {56'd0, w_shifted[7:0]};
      3'b010:  w_rd_data = {48'd0, w_shifted[15:0]};
      3'b011:  w_rd_data = {32'd0, w_shifted[31:0]};
      default: w_rd_data = w_shifted;
    endcase
    if (r_burst) w_rd_data = mem_rdata;
  end

  always_comb begin
    w_state_next     = r_state;
    w_beat_next      = r_beat;
    w_tmo_next       = r_tmo;
    w_off_next       = r_off;
    w_size_next      = r_size;
    w_we_next        = r_we;
    w_burst_next     = r_burst;
    w_dout_next      = r_dout;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_wstrb_next = r_mem_wstrb;
    case (r_state)
      S_IDLE: begin
        if (w_rd_ok || w_wr_ok) begin
          if ((w_rd_ok && w_wr_ok) || w_misalign) begin
            w_state_next = S_ERR;
            w_dout_next  = '0;
          end else begin
            w_state_next     = S_BUSY;
            w_off_next       = dram_addr[2:0];
            w_size_next      = w_ctrl;
            w_we_next        = w_wr_ok;
            w_burst_next     = (w_ctrl == 3'b110);
            w_beat_next      = '0;
            w_tmo_next       = '0;
            w_mem_req_next   = 1'b1;
            w_mem_we_next    = w_wr_ok;
            if (w_ctrl == 3'b110) begin
              w_mem_addr_next  = {dram_addr[63:6], 6'd0};
              w_mem_wdata_next = w_wr_ok ? dram_din : 64'd0;
              w_mem_wstrb_next = 8'hFF;
            end else begin
              w_mem_addr_next  = {dram_addr[63:3], 3'd0};
              w_mem_wdata_next = w_wr_ok ? (dram_din << {dram_addr[2:0], 3'b000}) : 64'd0;
              w_mem_wstrb_next = w_wr_ok ? (size_mask(w_ctrl) << dram_addr[2:0]) : 8'hFF;
            end
          end
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          w_state_next   = S_BEAT;
          w_mem_req_next = 1'b0;
          if (!r_we) w_dout_next = w_rd_data;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_state_next   = S_ERR;
          w_mem_req_next = 1'b0;
          w_beat_next    = '0;
          w_dout_next    = '0;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      S_BEAT: begin
        // Next write beat is taken from dram_din while this BEAT cycle is shown.
        if (r_burst && (r_beat != BW'(BURST_LEN - 1))) begin
          w_state_next    = S_BUSY;
          w_beat_next     = r_beat + 1'b1;
          w_tmo_next      = '0;
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = r_mem_addr + 64'd8;
          if (r_we) w_mem_wdata_next = dram_din;
        end else begin
          w_state_next = S_IDLE;
          w_beat_next  = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_beat_next  = '0;
        w_dout_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_tmo       <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_we        <= 1'b0;
      r_burst     <= 1'b0;
      r_dout      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_state     <= w_state_next;
      r_beat      <= w_beat_next;
      r_tmo       <= w_tmo_next;
      r_off       <= w_off_next;
      r_size      <= w_size_next;
      r_we        <= w_we_next;
      r_burst     <= w_burst_next;
      r_dout      <= w_dout_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_wstrb <= w_mem_wstrb_next;
    end
  end

  assign state     = r_state;
  assign dram_dout = r_dout;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl: a cycle-stepping memory responder with
// programmable ack wait, and hand-computed expectations per transaction.
module tb_dram_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] dram_addr, dram_din, dram_dout;
  logic [2:0]  dram_rd_ctrl, dram_wr_ctrl;
  logic [1:0]  state;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] beat_data [8];
  logic [63:0] cap_addr  [8];
  logic [63:0] cap_wdata [8];
  logic [7:0]  cap_strb  [8];
  logic        cap_we    [8];
  logic [63:0] cap_dout  [8];
  int          beat_cyc  [8];
  int n_beat, req_cycles, busy_total, err_cycles, unstable, lat;
  logic [63:0] err_dout;

  dram_ctrl #(.BURST_LEN(8), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .dram_addr(dram_addr), .dram_din(dram_din),
    .dram_rd_ctrl(dram_rd_ctrl), .dram_wr_ctrl(dram_wr_ctrl),
    .dram_dout(dram_dout), .state(state),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and step until the controller is back in IDLE.
  task automatic do_txn(input logic [2:0] rd, input logic [2:0] wr,
                        input logic [63:0] addr, input logic [63:0] din, input int waits);
    int cyc;
    int busy_cnt;
    n_beat = 0; req_cycles = 0; busy_total = 0; err_cycles = 0;
    unstable = 0; busy_cnt = 0; err_dout = '1;
    dram_rd_ctrl = rd; dram_wr_ctrl = wr; dram_addr = addr; dram_din = din;
    tick();
    dram_rd_ctrl = 3'b000; dram_wr_ctrl = 3'b000;
    dram_addr = 64'hFFFF_FFFF_FFFF_FFFF; dram_din = 64'h5A5A_5A5A_5A5A_5A5A;
    cyc = 1;
    while (state != 2'b00 && cyc < 2000) begin
      if (mem_req) req_cycles++;
      case (state)
        2'b01: begin
          if (n_beat < 8) begin
            if (busy_cnt == 0) begin
              cap_addr[n_beat] = mem_addr; cap_wdata[n_beat] = mem_wdata;
              cap_strb[n_beat] = mem_wstrb; cap_we[n_beat]    = mem_we;
            end else if (mem_addr !== cap_addr[n_beat] || mem_wdata !== cap_wdata[n_beat] ||
                         mem_wstrb !== cap_strb[n_beat] || mem_we !== cap_we[n_beat]) begin
              unstable++;
            end
            if (busy_cnt == waits) begin
              mem_ack = 1'b1;
              mem_rdata = beat_data[n_beat];
            end
          end
          busy_cnt++;
          busy_total++;
        end
        2'b10: begin
          if (n_beat < 8) begin
            cap_dout[n_beat] = dram_dout;
            beat_cyc[n_beat] = cyc;
          end
          n_beat++;
          busy_cnt = 0;
          dram_din = 64'(n_beat);
        end
        default: begin
          err_cycles++;
          err_dout = dram_dout;
        end
      endcase
      tick();
      mem_ack = 1'b0;
      cyc++;
    end
    lat = cyc;
    check("txn_finished", 64'(cyc < 2000), 64'd1);
  endtask

  initial begin
    int guard;
    int nb;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    dram_addr = '0; dram_din = '0; dram_rd_ctrl = '0; dram_wr_ctrl = '0;
    repeat (3) tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_dout", dram_dout, 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_wstrb", 64'(mem_wstrb), 64'd0);
    rst = 1'b0;

    // Dword read, ack in first BUSY cycle
    beat_data[0] = 64'h1122_3344_5566_7788;
    do_txn(3'b100, 3'b000, 64'h8000_0010, 64'd0, 0);
    check("dw_rd_addr", cap_addr[0], 64'h8000_0010);
    check("dw_rd_strb", 64'(cap_strb[0]), 64'hFF);
    check("dw_rd_we", 64'(cap_we[0]), 64'd0);
    check("dw_rd_beatcyc", 64'(beat_cyc[0]), 64'd2);
    check("dw_rd_dout", cap_dout[0], 64'h1122_3344_5566_7788);
    check("dw_rd_lat", 64'(lat), 64'd3);
    check("dw_rd_reqcyc", 64'(req_cycles), 64'd1);

    // Byte write into lane 5
    do_txn(3'b000, 3'b001, 64'h8000_0005, 64'h0000_0000_0000_00AB, 0);
    check("b_wr_addr", cap_addr[0], 64'h8000_0000);
    check("b_wr_strb", 64'(cap_strb[0]), 64'h20);
    check("b_wr_wdata", cap_wdata[0], 64'h0000_AB00_0000_0000);
    check("b_wr_we", 64'(cap_we[0]), 64'd1);
    check("b_wr_lat", 64'(lat), 64'd3);

    // Half read from upper lanes
    beat_data[0] = 64'hDEAD_0000_0000_0000;
    do_txn(3'b010, 3'b000, 64'h8000_0006, 64'd0, 0);
    check("h_rd_addr", cap_addr[0], 64'h8000_0000);
    check("h_rd_dout", cap_dout[0], 64'h0000_0000_0000_DEAD);

    // Word read, one wait cycle
    beat_data[0] = 64'hCAFE_BABE_1234_5678;
    do_txn(3'b011, 3'b000, 64'h8000_0004, 64'd0, 1);
    check("w_rd_dout", cap_dout[0], 64'h0000_0000_CAFE_BABE);
    check("w_rd_lat", 64'(lat), 64'd4);

    // Burst read, two wait cycles per beat
    for (int k = 0; k < 8; k++) beat_data[k] = 64'hB0B0_0000_0000_0000 + 64'(k * 17 + 3);
    do_txn(3'b110, 3'b000, 64'h8000_0128, 64'd0, 2);
    check("br_beats", 64'(n_beat), 64'd8);
    check("br_lat", 64'(lat), 64'd33);
    check("br_reqcyc", 64'(req_cycles), 64'd24);
    check("br_stable", 64'(unstable), 64'd0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("br_addr%0d", k), cap_addr[k], 64'h8000_0100 + 64'(8 * k));
      check($sformatf("br_dout%0d", k), cap_dout[k], 64'hB0B0_0000_0000_0000 + 64'(k * 17 + 3));
    end

    // Burst write, zero wait, din stepped during each BEAT
    do_txn(3'b000, 3'b110, 64'h8000_0140, 64'd0, 0);
    check("bw_lat", 64'(lat), 64'd17);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bw_addr%0d", k), cap_addr[k], 64'h8000_0140 + 64'(8 * k));
      check($sformatf("bw_wdata%0d", k), cap_wdata[k], 64'(k));
      check($sformatf("bw_strb%0d", k), 64'(cap_strb[k]), 64'hFF);
      check($sformatf("bw_we%0d", k), 64'(cap_we[k]), 64'd1);
    end

    // Misaligned word read
    do_txn(3'b011, 3'b000, 64'h8000_0002, 64'd0, 0);
    check("mis_err", 64'(err_cycles), 64'd1);
    check("mis_req", 64'(req_cycles), 64'd0);
    check("mis_dout", err_dout, 64'd0);
    check("mis_lat", 64'(lat), 64'd2);

    // Reload dout, then simultaneous read and write
    beat_data[0] = 64'h0123_4567_89AB_CDEF;
    do_txn(3'b100, 3'b000, 64'h8000_0020, 64'd0, 0);
    check("pre_dout", cap_dout[0], 64'h0123_4567_89AB_CDEF);
    do_txn(3'b100, 3'b100, 64'h8000_0020, 64'd0, 0);
    check("rw_err", 64'(err_cycles), 64'd1);
    check("rw_req", 64'(req_cycles), 64'd0);
    check("rw_dout", err_dout, 64'd0);
    check("rw_lat", 64'(lat), 64'd2);

    // Ack withheld
    do_txn(3'b100, 3'b000, 64'h8000_0030, 64'd0, 100000);
    check("to_busy", 64'(busy_total), 64'd255);
    check("to_err", 64'(err_cycles), 64'd1);
    check("to_lat", 64'(lat), 64'd257);
    check("to_dout", err_dout, 64'd0);

    // Reset during beat 3 of a burst (ack held high throughout)
    mem_ack = 1'b1; mem_rdata = 64'h7777_7777_7777_7777;
    dram_rd_ctrl = 3'b110; dram_addr = 64'h8000_0200;
    tick();
    dram_rd_ctrl = 3'b000;
    guard = 0; nb = 0;
    while (!(state == 2'b01 && nb == 3) && guard < 200) begin
      if (state == 2'b10) nb++;
      tick();
      guard++;
    end
    check("rb_reached", 64'(guard < 200), 64'd1);
    check("rb_addr3", mem_addr, 64'h8000_0218);
    rst = 1'b1; mem_ack = 1'b0;
    tick();
    check("rb_state", 64'(state), 64'd0);
    check("rb_req", 64'(mem_req), 64'd0);
    check("rb_dout", dram_dout, 64'd0);
    check("rb_maddr", mem_addr, 64'd0);
    rst = 1'b0;
    beat_data[0] = 64'hFEED_FACE_0000_1111;
    do_txn(3'b100, 3'b000, 64'h8000_0300, 64'd0, 0);
    check("rb_next_addr", cap_addr[0], 64'h8000_0300);
    check("rb_next_dout", cap_dout[0], 64'hFEED_FACE_0000_1111);
    check("rb_next_lat", 64'(lat), 64'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/dram_ctrl.md
# dram_ctrl

Memory-side controller directly downstream of the data cache. Accepts single-beat (byte/half/word/dword) and 8-beat line-burst read/write commands on the `dram_*` bus and reports progress on a 2-bit `state` output. Drives a one-outstanding-request req/ack port to the backing memory. Handles byte-lane alignment, write strobes, read extraction, misalignment detection and an ack timeout.

## Interface
- `BURST_LEN`, 8: beats per line burst (64 B line / 8 B bus).
- `TIMEOUT`, 255: cycles a beat may wait for `mem_ack` before error.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `dram_addr` in 64: byte address; low 6 bits ignored for bursts.
- `dram_din` in 64: write data, unshifted and LSB-aligned for singles; beat data for bursts.
- `dram_rd_ctrl` in 3: 001 byte, 010 half, 011 word, 100 dword, 110 burst; others = no-op.
- `dram_wr_ctrl` in 3: 001 byte, 010 half, 011 word, 100 dword, 110 burst; others = no-op.
- `dram_dout` out 64: read data, zero-extended and LSB-aligned for singles; beat data for bursts.
- `state` out 2: 00 IDLE, 01 BUSY, 10 BEAT, 11 ERR.
- `mem_req` out 1: request valid; held until ack.
- `mem_we` out 1: write request.
- `mem_addr` out 64: 8-byte-aligned address; `addr[2:0]` = 0.
- `mem_wdata` out 64: lane-positioned write data.
- `mem_wstrb` out 8: byte enables; all ones for reads.
- `mem_rdata` in 64: read data, valid in the ack cycle.
- `mem_ack` in 1: completes the current request in the cycle it is high with `mem_req`.

## Operation
- Reset values: `state` = 00, `dram_dout` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_wstrb` = 0. Beat counter and timeout counter are cleared.
- Command sampling happens only in IDLE, when a valid (non-no-op) code is present.
  - Address, controls and `dram_din` are captured.
  - Inputs are ignored in all other states.
- Go to ERR without issuing a memory request when any of these hold:
  - both read and write are valid at once;
  - half-word access with `addr[0]` set;
  - word access with `addr[1:0]` ≠ 0;
  - dword access with `addr[2:0]` ≠ 0.
- Single write:
  - `mem_wdata` = `din << (addr[2:0]*8)`.
  - `mem_wstrb` = (1/3/15/255) << `addr[2:0]`.
- Single read: `dram_dout` = (`mem_rdata` >> `addr[2:0]*8`), masked to 8/16/32/64 bits, registered on ack.
- Burst:
  - Beat k uses `mem_addr` = {`addr[63:6]`, 6'b0} + 8k, for k = 0..BURST_LEN-1.
  - Reads: `dram_dout` takes beat k data on ack k.
  - Writes: beat 0 data is captured at command sampling. Beat k (k ≥ 1) data is sampled from `dram_din` during the BEAT cycle of beat k-1.
- State machine:
  - IDLE → BUSY on a valid command; IDLE → ERR on an illegal one.
  - BUSY: `mem_req` = 1. On `mem_ack`, go to BEAT. If the timeout counter reaches TIMEOUT without ack, go to ERR.
  - BEAT lasts one cycle with `mem_req` = 0. It goes to BUSY if beats remain, otherwise to IDLE.
  - ERR lasts one cycle: `dram_dout` = 0, then IDLE.
- The timeout counter resets at each BUSY entry and counts BUSY cycles.
- The beat counter wraps to 0 on burst completion or error.
- `dram_dout` holds its last value except on ack (loaded) and in ERR (zeroed).

## Timing
- All outputs are registered.
- Single access with ack in the first BUSY cycle:
  - sample at cycle 0;
  - BUSY/`mem_req` at cycle 1;
  - BEAT at cycle 2, with `dram_dout` valid;
  - IDLE at cycle 3.
- Latency = 3 + wait cycles.
- Zero-wait burst: 1 + 2·BURST_LEN = 17 cycles from sample to IDLE.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are stable throughout each BUSY period.
- Upstream must hold the next write-beat data while `state` = BEAT.
- A command presented in the cycle `state` returns to IDLE is sampled in that cycle.
- Reset asserted mid-transaction:
  - all outputs return to reset values at the next edge;
  - `mem_req` drops even without ack; the memory side must tolerate the abandoned request.
- `mem_ack` while `mem_req` = 0 is ignored.

## Test plan
- Single dword read, addr 0x8000_0010, `mem_rdata` 0x1122334455667788, ack on the first req cycle → `mem_addr` 0x8000_0010, `mem_wstrb` 0xFF; BEAT at cycle 2 with `dram_dout` 0x1122334455667788; IDLE at cycle 3.
- Byte write, addr 0x8000_0005, din 0xAB → `mem_wstrb` 0x20, `mem_wdata[47:40]` = 0xAB; half read at addr 0x8000_0006 with `mem_rdata` 0xDEAD_0000_0000_0000 → `dram_dout` 0xDEAD.
- Burst read, addr 0x8000_0128, ack with 2 wait cycles per beat → `mem_addr` sequence 0x8000_0100..0x8000_0138, 8 BEAT pulses, `dram_dout` equal to each beat's data, 33 cycles total.
- Burst write with din changed during each BEAT to 0..7 → `mem_wdata` beats 0..7 in order, `mem_wstrb` 0xFF, `mem_we` = 1.
- Word read at addr 0x8000_0002, and simultaneous rd+wr → ERR for one cycle, no `mem_req`, `dram_dout` = 0, then IDLE.
- `mem_ack` withheld → ERR after 255 BUSY cycles. Separately, `rst` asserted during beat 3 of a burst → `mem_req` = 0 and `state` = 00 at the next edge, and the next command proceeds normally.
